dcache_wb_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU's EX/MEM stage outputs (address, write data, MemRead/MemWrite) and a multi-cycle backing data memory.
- Serves hits in the same cycle. On a miss it holds the pipeline with cpu_stall_o while it writes back a dirty victim line and refills the line.

---
 rtl/dcache_wb_dm.sv | 165 ++++++++++++++++
 tb/tb_dcache_wb_dm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the EX/MEM stage
// and a multi-cycle line-wide backing memory. Hits finish in the same cycle; misses stall.
module dcache_wb_dm #(
  parameter int LINES = 32,
  parameter int WORDS = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic [31:0]           cpu_rdata_o,
  output logic                  cpu_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [32*WORDS-1:0]   mem_wdata_o,
  input  logic [32*WORDS-1:0]   mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [CNT_W-1:0]      hit_cnt_o,
  output logic [CNT_W-1:0]      miss_cnt_o
);
  localparam int WORD_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 32 * WORDS;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t              state_reg, state_next;
  logic [LINES-1:0]    valid_reg, dirty_reg;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [LINE_W-1:0]   data_mem [LINES];

  logic                mem_req_reg, mem_req_next;
  logic                mem_we_reg, mem_we_next;
  logic [31:0]         mem_addr_reg, mem_addr_next;
  logic [LINE_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [CNT_W-1:0]    hit_cnt_reg, miss_cnt_reg;

  logic [WORD_W-1:0]   addr_word;
  logic [IDX_W-1:0]    addr_idx;
  logic [TAG_W-1:0]    addr_tag;
  logic [LINE_W-1:0]   line_rd;
  logic [31:0]         line_words [WORDS];
  logic [31:0]         fill_addr;
  logic                hit, miss, fill_done;
  logic                unused_addr_bits;

  assign addr_word        = cpu_addr_i[OFF_W-1:2];
  assign addr_idx         = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign addr_tag         = cpu_addr_i[31:OFF_W+IDX_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign fill_addr        = {cpu_addr_i[31:OFF_W], {OFF_W{1'b0}}};

  assign line_rd = data_mem[addr_idx];
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign line_words[gi] = line_rd[gi*32 +: 32];
  end

  // Lookups only count in IDLE; during WB/FILL the held request is already a miss.
  assign hit       = cpu_req_i && (state_reg == IDLE) && valid_reg[addr_idx] &&
                     (tag_mem[addr_idx] == addr_tag);
  assign miss      = cpu_req_i && (state_reg == IDLE) && !hit;
  assign fill_done = (state_reg == FILL) && mem_ack_i;

  assign cpu_stall_o = miss || (state_reg != IDLE);
  assign cpu_rdata_o = hit ? line_words[addr_word] : 32'h0;

  assign mem_req_o   = mem_req_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign hit_cnt_o   = hit_cnt_reg;
  assign miss_cnt_o  = miss_cnt_reg;

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (miss) begin
          mem_req_next = 1'b1;
          if (valid_reg[addr_idx] && dirty_reg[addr_idx]) begin
            state_next     = WB;
            mem_we_next    = 1'b1;
            mem_addr_next  = {tag_mem[addr_idx], addr_idx, {OFF_W{1'b0}}};
            mem_wdata_next = line_rd;
          end else begin
            state_next    = FILL;
            mem_we_next   = 1'b0;
            mem_addr_next = fill_addr;
          end
        end
      end
      WB: begin
        // Request stays up and turns straight into the fetch of the missing line.
        if (mem_ack_i) begin
          state_next    = FILL;
          mem_we_next   = 1'b0;
          mem_addr_next = fill_addr;
        end
      end
      FILL: begin
        if (mem_ack_i) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        mem_we_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if (fill_done) begin
        valid_reg[addr_idx] <= 1'b1;
        dirty_reg[addr_idx] <= 1'b0;
      end else if (hit && cpu_we_i) begin
        dirty_reg[addr_idx] <= 1'b1;
      end
      if (hit && (hit_cnt_reg != {CNT_W{1'b1}}))
        hit_cnt_reg <= hit_cnt_reg + 1'b1;
      if (miss && (miss_cnt_reg != {CNT_W{1'b1}}))
        miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity is tracked by valid_reg alone.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_mem[addr_idx] <= mem_rdata_i;
      tag_mem[addr_idx]  <= addr_tag;
    end else if (hit && cpu_we_i) begin
      data_mem[addr_idx][addr_word*32 +: 32] <= cpu_wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed bench for dcache_wb_dm: a line-wide memory responder with configurable
// latency logs every request; the main sequence checks CPU-side and memory-side behaviour.
module tb_dcache_wb_dm;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o, mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o, mem_rdata_i;
  logic         mem_ack_i;
  logic [15:0]  hit_cnt_o, miss_cnt_o;

  always #5 clk_i = ~clk_i;

  dcache_wb_dm dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory responder: acks each request lat_cfg cycles after it first appears.
  bit           resp_en = 1'b0;
  int           lat_cfg = 3;
  logic [127:0] fill_data = '0;
  logic         ack_resp = 1'b0;
  logic         ack_man  = 1'b0;
  logic         log_we [$];
  logic [31:0]  log_addr [$];
  logic [127:0] log_wd [$];

  assign mem_ack_i = ack_resp | ack_man;

  initial begin
    mem_rdata_i = '0;
    @(posedge clk_i); #2;
    forever begin
      if (resp_en && mem_req_o === 1'b1) begin
        log_we.push_back(mem_we_o);
        log_addr.push_back(mem_addr_o);
        log_wd.push_back(mem_wdata_o);
        repeat (lat_cfg - 1) begin @(posedge clk_i); #2; end
        ack_resp    = 1'b1;
        mem_rdata_i = fill_data;
        @(posedge clk_i); #2;
        ack_resp = 1'b0;
      end else begin
        @(posedge clk_i); #2;
      end
    end
  end

  // Entered and left 1 time unit after a rising edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rd, output logic first_stall);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    #2;
    stalls = 0;
    first_stall = cpu_stall_o;
    while (cpu_stall_o && stalls < 50) begin
      stalls++;
      @(posedge clk_i); #3;
    end
    if (stalls >= 50) check_val("access_timeout", cpu_stall_o, 1'b0);
    rd = cpu_rdata_o;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
  endtask

  task automatic expect_mem(input string tag, input logic we, input logic [31:0] addr,
                            input bit chk_wd, input logic [127:0] wd);
    logic         w;
    logic [31:0]  a;
    logic [127:0] d;
    if (log_we.size() == 0) begin
      check_val({tag, "_present"}, log_we.size(), 1);
      return;
    end
    w = log_we.pop_front(); a = log_addr.pop_front(); d = log_wd.pop_front();
    check_val({tag, "_we"}, w, we);
    check_val({tag, "_addr"}, a, addr);
    if (chk_wd) check_val({tag, "_wdata"}, d, wd);
  endtask

  int          st;
  logic [31:0] rd;
  logic        fs;

  initial begin
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0; #2;
    check_val("rst_stall", cpu_stall_o, 1'b0);
    check_val("rst_mem_req", mem_req_o, 1'b0);
    check_val("rst_mem_we", mem_we_o, 1'b0);
    check_val("rst_mem_addr", mem_addr_o, 32'h0);
    check_val("rst_mem_wdata", mem_wdata_o, 128'h0);
    check_val("rst_hit_cnt", hit_cnt_o, 16'h0);
    check_val("rst_miss_cnt", miss_cnt_o, 16'h0);
    @(posedge clk_i); #1;
    resp_en = 1'b1;

    // Cold load miss at 0x40 (index 4, tag 0), clean fill with latency 3.
    lat_cfg = 3;
    fill_data = {32'h1000_0003, 32'h1000_0002, 32'hDEAD_BEEF, 32'h1000_0000};
    access(1'b0, 32'h0000_0040, 32'h0, st, rd, fs);
    check_val("t1_stall_same_cycle", fs, 1'b1);
    check_val("t1_stalls", st, 4);
    check_val("t1_rdata", rd, 32'h1000_0000);
    expect_mem("t1_fill", 1'b0, 32'h0000_0040, 1'b0, '0);
    access(1'b0, 32'h0000_0044, 32'h0, st, rd, fs);
    check_val("t1_hit_stalls", st, 0);
    check_val("t1_hit_rdata", rd, 32'hDEAD_BEEF);
    check_val("t1_miss_cnt", miss_cnt_o, 16'd1);
    check_val("t1_hit_cnt", hit_cnt_o, 16'd2);

    // Store hit dirties the line; conflicting load 0x244 forces WB then FILL.
    access(1'b1, 32'h0000_0044, 32'h1234_5678, st, rd, fs);
    check_val("t2_store_stalls", st, 0);
    fill_data = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
    access(1'b0, 32'h0000_0244, 32'h0, st, rd, fs);
    check_val("t2_stalls", st, 7);
    check_val("t2_rdata", rd, 32'h2000_0001);
    expect_mem("t2_wb", 1'b1, 32'h0000_0040, 1'b1,
               {32'h1000_0003, 32'h1000_0002, 32'h1234_5678, 32'h1000_0000});
    expect_mem("t2_fill", 1'b0, 32'h0000_0240, 1'b0, '0);

    // Clean victim: back to tag 0 at index 4, fill only.
    fill_data = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    access(1'b0, 32'h0000_0044, 32'h0, st, rd, fs);
    check_val("t3_stalls", st, 4);
    check_val("t3_rdata", rd, 32'h3000_0001);
    expect_mem("t3_fill", 1'b0, 32'h0000_0040, 1'b0, '0);
    check_val("t3_no_extra_req", log_we.size(), 0);

    // Store miss at 0x80 merges after a zero fill; 0x280 then writes it back.
    lat_cfg = 2;
    fill_data = '0;
    access(1'b1, 32'h0000_0080, 32'hCAFE_F00D, st, rd, fs);
    check_val("t4_store_stalls", st, 3);
    expect_mem("t4_fill", 1'b0, 32'h0000_0080, 1'b0, '0);
    fill_data = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
    access(1'b0, 32'h0000_0280, 32'h0, st, rd, fs);
    check_val("t4_stalls", st, 5);
    check_val("t4_rdata", rd, 32'h4000_0000);
    expect_mem("t4_wb", 1'b1, 32'h0000_0080, 1'b1, {96'h0, 32'hCAFE_F00D});
    expect_mem("t4_fill", 1'b0, 32'h0000_0280, 1'b0, '0);
    check_val("t4_miss_cnt", miss_cnt_o, 16'd5);
    check_val("t4_hit_cnt", hit_cnt_o, 16'd7);

    // Reset in the middle of a FILL, then a late ack.
    resp_en = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0100;
    @(posedge clk_i); #1;
    @(posedge clk_i); #3;
    check_val("t5_fill_req", mem_req_o, 1'b1);
    check_val("t5_fill_addr", mem_addr_o, 32'h0000_0100);
    @(posedge clk_i); #1;
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; #2;
    check_val("t5_req_dropped", mem_req_o, 1'b0);
    @(posedge clk_i); #1;
    ack_man = 1'b1;
    @(posedge clk_i); #1;
    ack_man = 1'b0; #2;
    check_val("t5_late_ack_req", mem_req_o, 1'b0);
    check_val("t5_idle_stall", cpu_stall_o, 1'b0);
    check_val("t5_miss_cnt_rst", miss_cnt_o, 16'd0);
    @(posedge clk_i); #1;
    resp_en = 1'b1;
    lat_cfg = 1;
    fill_data = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
    access(1'b0, 32'h0000_0044, 32'h0, st, rd, fs);
    check_val("t5_remiss", fs, 1'b1);
    check_val("t5_stalls", st, 2);
    check_val("t5_rdata", rd, 32'h5000_0001);
    expect_mem("t5_fill", 1'b0, 32'h0000_0040, 1'b0, '0);
    check_val("t5_hit_cnt", hit_cnt_o, 16'd1);

    // Hit counter saturation with a stream of back-to-back load hits.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0044;
    repeat (65533) @(posedge clk_i);
    #1;
    check_val("t6_hit_cnt_fffe", hit_cnt_o, 16'hFFFE);
    @(posedge clk_i); #1;
    check_val("t6_hit_cnt_ffff", hit_cnt_o, 16'hFFFF);
    repeat (3) @(posedge clk_i);
    #1;
    check_val("t6_hit_cnt_sat", hit_cnt_o, 16'hFFFF);
    check_val("t6_miss_cnt", miss_cnt_o, 16'd1);
    cpu_req_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
